// File: rtl/div_unit_if.sv
// Handshake and result bus between the execute stage and the iterative divider.
// The pipeline side (master) issues operands and watches stall/ready; the
// divider (slave) returns the HI/LO results.
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             signed_div;
  logic             annul;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             stall;
  logic             ready;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;

  modport master (
    output start, signed_div, annul, opa, opb,
    input  stall, ready, hi_out, lo_out
  );

  modport slave (
    input  start, signed_div, annul, opa, opb,
    output stall, ready, hi_out, lo_out
  );
endinterface

// File: rtl/div_unit.sv
// Iterative restoring divider for DIV/DIVU. Works on operand magnitudes,
// retires one quotient bit per clock (MSB first) and fixes up the result
// signs when the last step lands, so a full divide takes 32 BUSY cycles
// followed by a single DONE cycle carrying the ready pulse.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [5:0] LAST_STEP = 6'(WIDTH - 1);

  state_t           stateR;
  logic [5:0]       cntR;
  logic             signedR;
  logic             signAR;
  logic             signBR;
  logic [WIDTH-1:0] quoR;     // dividend magnitude shifts out, quotient bits shift in
  logic [WIDTH-1:0] divR;     // divisor magnitude
  logic [WIDTH-1:0] remR;     // partial remainder
  logic             readyR;
  logic [WIDTH-1:0] hiR;
  logic [WIDTH-1:0] loR;

  logic [WIDTH-1:0] absAS;
  logic [WIDTH-1:0] absBS;
  logic [WIDTH:0]   remShiftS;
  logic [WIDTH:0]   trialS;
  logic             qBitS;
  logic [WIDTH-1:0] remNextS;
  logic [WIDTH-1:0] quoNextS;
  logic [WIDTH-1:0] quoFinalS;
  logic [WIDTH-1:0] remFinalS;
  logic             acceptS;

  // Operand magnitudes; unsigned divides pass the raw bits straight through.
  always_comb begin
    absAS = bus.opa;
    absBS = bus.opb;
    if (bus.signed_div && bus.opa[WIDTH-1]) begin
      absAS = -bus.opa;
    end else begin
      absAS = bus.opa;
    end
    if (bus.signed_div && bus.opb[WIDTH-1]) begin
      absBS = -bus.opb;
    end else begin
      absBS = bus.opb;
    end
  end

  // One restoring step: try subtracting the divisor from the shifted remainder,
  // keep the difference only when it did not go negative.
  always_comb begin
    remShiftS = {remR, quoR[WIDTH-1]};
    trialS    = remShiftS - {1'b0, divR};
    qBitS     = ~trialS[WIDTH];
    if (qBitS) begin
      remNextS = trialS[WIDTH-1:0];
    end else begin
      remNextS = remShiftS[WIDTH-1:0];
    end
    quoNextS = {quoR[WIDTH-2:0], qBitS};
  end

  // Sign fix-up of the final step: quotient negated on differing signs,
  // remainder follows the dividend. MIN/-1 wraps back to MIN naturally.
  always_comb begin
    quoFinalS = quoNextS;
    remFinalS = remNextS;
    if (signedR && (signAR ^ signBR)) begin
      quoFinalS = -quoNextS;
    end else begin
      quoFinalS = quoNextS;
    end
    if (signedR && signAR) begin
      remFinalS = -remNextS;
    end else begin
      remFinalS = remNextS;
    end
  end

  assign acceptS    = (stateR == IDLE) && bus.start && !bus.annul;
  assign bus.stall  = acceptS || (stateR == BUSY);
  assign bus.ready  = readyR && !bus.annul;
  assign bus.hi_out = hiR;
  assign bus.lo_out = loR;

  // Control FSM, iteration datapath and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateR  <= IDLE;
      cntR    <= 6'd0;
      signedR <= 1'b0;
      signAR  <= 1'b0;
      signBR  <= 1'b0;
      quoR    <= {WIDTH{1'b0}};
      divR    <= {WIDTH{1'b0}};
      remR    <= {WIDTH{1'b0}};
      readyR  <= 1'b0;
      hiR     <= {WIDTH{1'b0}};
      loR     <= {WIDTH{1'b0}};
    end else begin
      case (stateR)
        IDLE: begin
          readyR <= 1'b0;
          if (acceptS) begin
            signedR <= bus.signed_div;
            signAR  <= bus.opa[WIDTH-1];
            signBR  <= bus.opb[WIDTH-1];
            quoR    <= absAS;
            divR    <= absBS;
            remR    <= {WIDTH{1'b0}};
            cntR    <= 6'd0;
            if (bus.opb == {WIDTH{1'b0}}) begin
              // Divide by zero: architected result without iterating.
              loR    <= {WIDTH{1'b1}};
              hiR    <= bus.opa;
              readyR <= 1'b1;
              stateR <= DONE;
            end else begin
              stateR <= BUSY;
            end
          end else begin
            stateR <= IDLE;
          end
        end
        BUSY: begin
          if (bus.annul) begin
            stateR <= IDLE;
            readyR <= 1'b0;
          end else begin
            quoR <= quoNextS;
            remR <= remNextS;
            cntR <= cntR + 6'd1;
            if (cntR == LAST_STEP) begin
              loR    <= quoFinalS;
              hiR    <= remFinalS;
              readyR <= 1'b1;
              stateR <= DONE;
            end else begin
              readyR <= 1'b0;
              stateR <= BUSY;
            end
          end
        end
        DONE: begin
          readyR <= 1'b0;
          stateR <= IDLE;
        end
        default: begin
          readyR <= 1'b0;
          stateR <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: stimulus pushes the expected HI/LO and the
// cycle the ready pulse must appear in; a monitor pops on every ready.
module tb_div_unit;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   total;
  int   bad;
  exp_t sbQ[$];

  div_unit_if #(.WIDTH(32)) bus ();

  div_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every ready pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst && bus.ready) begin
      if (sbQ.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_ready: got ready=1 expected none (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sbQ.pop_front();
        chk("lo_out", bus.lo_out, e.lo);
        chk("hi_out", bus.hi_out, e.hi);
        chk("ready_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Issue one division, push its expectation and check stall every cycle.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                       input logic [31:0] expHi, input logic [31:0] expLo);
    int   lat;
    exp_t e;
    lat = (b == 32'd0) ? 1 : 33;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.opa = a; bus.opb = b; bus.signed_div = sgn;
    e.hi = expHi; e.lo = expLo; e.cyc = cyc + lat;
    sbQ.push_back(e);
    for (int i = 0; i <= lat; i++) begin
      @(negedge clk);
      chk("stall", {31'd0, bus.stall}, (i < lat) ? 32'd1 : 32'd0);
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.opa = $urandom;
      bus.opb = $urandom;
      bus.signed_div = 1'($urandom_range(1, 0));
    end
  endtask

  initial begin
    int c0;
    cyc = 0; total = 0; bad = 0;
    rst = 1'b0;
    bus.start = 1'b0; bus.signed_div = 1'b0; bus.annul = 1'b0;
    bus.opa = 32'd0; bus.opb = 32'd0;
    #2;
    chk("rst_lo", bus.lo_out, 32'd0);
    chk("rst_hi", bus.hi_out, 32'd0);
    chk("rst_ready", {31'd0, bus.ready}, 32'd0);
    chk("rst_stall", {31'd0, bus.stall}, 32'd0);
    @(negedge clk); rst = 1'b1;

    issue(32'd100,        32'd7,        1'b0, 32'd2,        32'd14);
    issue(32'hFFFFFFF9,   32'd2,        1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD);
    issue(32'hFFFFFFF9,   32'd2,        1'b0, 32'd1,        32'h7FFFFFFC);
    issue(32'h80000000,   32'hFFFFFFFF, 1'b1, 32'd0,        32'h80000000);
    issue(32'h00001234,   32'd0,        1'b0, 32'h00001234, 32'hFFFFFFFF);
    issue(32'd7,          32'hFFFFFFFE, 1'b1, 32'd1,        32'hFFFFFFFD);
    issue(32'hFFFFFFF9,   32'hFFFFFFFE, 1'b1, 32'hFFFFFFFF, 32'd3);
    issue(32'hFFFFFFFB,   32'd0,        1'b1, 32'hFFFFFFFB, 32'hFFFFFFFF);
    issue(32'hFFFFFFFF,   32'd1,        1'b0, 32'd0,        32'hFFFFFFFF);
    issue(32'd5,          32'd9,        1'b0, 32'd5,        32'd0);
    issue(32'd100,        32'd7,        1'b0, 32'd2,        32'd14);

    // Annul mid-BUSY: no ready, outputs hold 14/2, next divide is clean.
    @(posedge clk); #1;
    c0 = cyc;
    bus.start = 1'b1; bus.opa = 32'd9; bus.opb = 32'd4; bus.signed_div = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    while (cyc < c0 + 10) begin
      @(posedge clk); #1;
    end
    bus.annul = 1'b1;
    @(negedge clk);
    chk("annul_busy_stall", {31'd0, bus.stall}, 32'd1);
    @(posedge clk); #1;
    bus.annul = 1'b0;
    @(negedge clk);
    chk("annul_idle_stall", {31'd0, bus.stall}, 32'd0);
    chk("annul_hold_lo", bus.lo_out, 32'd14);
    chk("annul_hold_hi", bus.hi_out, 32'd2);
    repeat (40) @(posedge clk);
    chk("annul_late_lo", bus.lo_out, 32'd14);
    issue(32'd9, 32'd4, 1'b0, 32'd1, 32'd2);

    // start together with annul in IDLE is dropped.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.annul = 1'b1; bus.opa = 32'd50; bus.opb = 32'd5;
    @(negedge clk);
    chk("start_annul_stall", {31'd0, bus.stall}, 32'd0);
    @(posedge clk); #1;
    bus.start = 1'b0; bus.annul = 1'b0;
    @(negedge clk);
    chk("start_annul_idle", {31'd0, bus.stall}, 32'd0);
    repeat (40) @(posedge clk);

    // Reset in cycle 15 of a divide clears outputs with no clock edge.
    @(posedge clk); #1;
    c0 = cyc;
    bus.start = 1'b1; bus.opa = 32'd100; bus.opb = 32'd7; bus.signed_div = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    while (cyc < c0 + 15) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    #1;
    chk("midrst_lo", bus.lo_out, 32'd0);
    chk("midrst_hi", bus.hi_out, 32'd0);
    chk("midrst_ready", {31'd0, bus.ready}, 32'd0);
    chk("midrst_stall", {31'd0, bus.stall}, 32'd0);
    @(negedge clk); rst = 1'b1;
    issue(32'd6, 32'd3, 1'b0, 32'd0, 32'd2);

    repeat (40) @(posedge clk);
    chk("scoreboard_empty", 32'(sbQ.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width; only 32 is supported.
REQ-002 Port clk  input  1: single clock; all state changes on its rising edge.
REQ-003 Port rst  input  1: asynchronous, active-low reset.
REQ-004 Port start  input  1: request a division, sampled only in IDLE.
REQ-005 Port signed_div  input  1: 1 = signed (DIV), 0 = unsigned (DIVU), sampled with start.
REQ-006 Port annul  input  1: abort the operation in flight (execute-stage flush).
REQ-007 Port opa  input  WIDTH: dividend, sampled with start.
REQ-008 Port opb  input  WIDTH: divisor, sampled with start.
REQ-009 Port stall  output  1: pipeline stall request to the hazard unit.
REQ-010 Port ready  output  1: one-cycle result-valid pulse; qualifies the HI/LO write.
REQ-011 Port hi_out  output  WIDTH: remainder, destined for HI.
REQ-012 Port lo_out  output  WIDTH: quotient, destined for LO.

Function
REQ-013 The unit SHALL implement a three-state machine, IDLE, BUSY and DONE, with a 6-bit iteration counter.
REQ-014 In IDLE with start=1 and annul=0, the unit SHALL latch the operands, the signed_div flag and the sign bits of opa and opb; it SHALL load |opa| and |opb| (magnitudes used only when signed_div=1); it SHALL clear the counter and enter BUSY.
REQ-015 In IDLE with start=1, annul=0 and opb=0, the unit SHALL enter DONE directly and SHALL NOT iterate.
REQ-016 In BUSY, the unit SHALL perform one restoring shift-subtract step on the magnitudes per clock, producing one quotient bit MSB-first and incrementing the counter.
REQ-017 After the 32nd step, the unit SHALL enter DONE; no early termination.
REQ-018 DONE SHALL last exactly one cycle, with ready=1, and SHALL then return to IDLE.
REQ-019 Latency: ready SHALL be high in the 33rd cycle after the cycle in which start was sampled (the start cycle is cycle 0); for divide-by-zero, ready SHALL be high in cycle 1.
REQ-020 stall SHALL be combinationally 1 when (state==IDLE and start=1 and annul=0) or state==BUSY, and 0 otherwise, including in DONE.
REQ-021 Signed results:
- quotient SHALL be negated when the sign of opa differs from the sign of opb;
- remainder SHALL take the sign of opa;
- negation is two's complement, truncated to WIDTH.
REQ-022 0x80000000 / 0xFFFFFFFF signed SHALL yield lo_out=0x80000000 and hi_out=0 without any error indication.
REQ-023 Divide-by-zero SHALL yield lo_out=0xFFFFFFFF and hi_out=opa as latched.
REQ-024 hi_out and lo_out SHALL update only when entering DONE and SHALL hold their values until the next DONE.
REQ-025 annul=1 in BUSY or DONE SHALL force IDLE on the next edge; ready SHALL be 0 in that cycle, outputs SHALL keep their previous values, and the partial result SHALL be discarded.
REQ-026 annul=1 together with start=1 in IDLE SHALL leave the unit in IDLE with stall=0.
REQ-027 start in BUSY or DONE SHALL be ignored; a new start SHALL be accepted in the IDLE cycle following DONE (minimum issue interval 34 cycles).
REQ-028 Operand inputs SHALL be don't-care outside the start-sampling cycle.

Reset
REQ-029 rst=0 SHALL asynchronously force the following, regardless of the clock: state=IDLE, counter=0, ready=0, stall=0, hi_out=0, lo_out=0, internal operand registers=0.
REQ-030 Reset asserted mid-BUSY SHALL abandon the operation; after release, the unit SHALL accept a fresh start with no residual state.
REQ-031 The first start SHALL be accepted on the first rising edge after rst deasserts.

Verification
REQ-032 Unsigned 100 / 7, start at cycle 0 -> stall=1 in cycles 0-32, ready=1 only in cycle 33, lo_out=14, hi_out=2.
REQ-033 Signed 0xFFFFFFF9 (-7) / 2 -> lo_out=0xFFFFFFFD, hi_out=0xFFFFFFFF; unsigned on the same operands -> lo_out=0x7FFFFFFC, hi_out=1.
REQ-034 Signed 0x80000000 / 0xFFFFFFFF -> lo_out=0x80000000, hi_out=0, ready in cycle 33.
REQ-035 Unsigned 0x1234 / 0 -> ready in cycle 1, lo_out=0xFFFFFFFF, hi_out=0x1234, stall=1 only in cycle 0.
REQ-036 Complete 100/7, then start 9/4 and pulse annul in cycle 10 -> IDLE in cycle 11, no ready pulse, outputs remain 14/2; a subsequent start of 9/4 -> lo_out=2, hi_out=1.
REQ-037 rst=0 in cycle 15 of a division -> outputs 0 immediately without a clock edge, no ready pulse; after release, 6/3 -> lo_out=2, hi_out=0 in cycle 33.
